// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the ram arbiter slice.
//   - state_e           arbiter FSM states
//   - REQ0 / REQ1       requester ids (values driven on 'owner')
//   - DEFAULT_*         default widths and ram depth
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        WAIT_LO = 3'd2,
        BYPASS  = 3'd3,
        ACK     = 3'd4
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_SIZE   = 4096;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection for the two ram requesters.
// Ports:
//   req          in   request levels, bit 0 = requester 0, bit 1 = requester 1
//   rr_ptr       in   id that holds priority on a contended grant (round-robin build only)
//   grant_valid  out  at least one request is pending
//   grant_id     out  id of the selected requester
// Build option: RAM_ARB_RR_EN selects round-robin; otherwise fixed priority r0 > r1.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef RAM_ARB_RR_EN
    input  logic       rr_ptr,
`endif
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = REQ0;
`ifdef RAM_ARB_RR_EN
        // On contention the pointer decides; otherwise whoever is asking wins.
        if (req[0] && req[1]) begin
            grant_id = rr_ptr;
        end else if (req[1]) begin
            grant_id = REQ1;
        end
`else
        if (!req[0] && req[1]) begin
            grant_id = REQ1;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port, change-triggered ram between two requesters.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rN_req/mode/address/data        requester N request level and operation tuple
//   rN_ack, rN_out                  one-cycle completion pulse and read data
//   ram_address/ram_data/ram_mode   registered ram inputs, held from grant to ack
//   ram_response, ram_out           ram busy flag (1 = busy) and read data
//   busy, owner                     FSM not idle, id of granted requester
// Build option: RAM_ARB_RR_EN enables round-robin arbitration (see ram_arb_pick).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int SIZE   = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_mode,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_out,
    input  logic              r1_req,
    input  logic              r1_mode,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_mode,
    input  logic              ram_response,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              owner
);

    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_mode_q, ram_mode_d;
    logic [ADDR_W-1:0] shadow_address_q, shadow_address_d;
    logic [DATA_W-1:0] shadow_data_q, shadow_data_d;
    logic              shadow_mode_q, shadow_mode_d;
    logic              shadow_valid_q, shadow_valid_d;
    logic [DATA_W-1:0] last_read_q, last_read_d;
    logic [DATA_W-1:0] r0_out_q, r0_out_d;
    logic [DATA_W-1:0] r1_out_q, r1_out_d;
    logic              r0_ack_q, r0_ack_d;
    logic              r1_ack_q, r1_ack_d;
`ifdef RAM_ARB_RR_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    logic              grant_valid;
    logic              grant_id;
    logic [ADDR_W-1:0] win_address;
    logic [ADDR_W-1:0] win_address_mod;
    logic [DATA_W-1:0] win_data;
    logic              win_mode;
    logic              win_is_repeat;

    ram_arb_pick u_pick (
        .req         ({r1_req, r0_req}),
`ifdef RAM_ARB_RR_EN
        .rr_ptr      (rr_ptr_q),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign win_address     = (grant_id == REQ1) ? r1_address : r0_address;
    assign win_data        = (grant_id == REQ1) ? r1_data    : r0_data;
    assign win_mode        = (grant_id == REQ1) ? r1_mode    : r0_mode;
    assign win_address_mod = win_address % SIZE_A;

    // The ram only starts on an input change, so re-issuing the last tuple would hang.
    assign win_is_repeat = shadow_valid_q
                        && (win_address_mod == shadow_address_q)
                        && (win_data == shadow_data_q)
                        && (win_mode == shadow_mode_q);

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        ram_address_d    = ram_address_q;
        ram_data_d       = ram_data_q;
        ram_mode_d       = ram_mode_q;
        shadow_address_d = shadow_address_q;
        shadow_data_d    = shadow_data_q;
        shadow_mode_d    = shadow_mode_q;
        shadow_valid_d   = shadow_valid_q;
        last_read_d      = last_read_q;
        r0_out_d         = r0_out_q;
        r1_out_d         = r1_out_q;
        r0_ack_d         = 1'b0;
        r1_ack_d         = 1'b0;
`ifdef RAM_ARB_RR_EN
        rr_ptr_d         = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                // A high ram_response here means a stray op is still finishing.
                if (grant_valid && !ram_response) begin
                    owner_d = grant_id;
`ifdef RAM_ARB_RR_EN
                    rr_ptr_d = ~grant_id;
`endif
                    if (win_is_repeat) begin
                        state_d = BYPASS;
                    end else begin
                        ram_address_d    = win_address;
                        ram_data_d       = win_data;
                        ram_mode_d       = win_mode;
                        shadow_address_d = win_address_mod;
                        shadow_data_d    = win_data;
                        shadow_mode_d    = win_mode;
                        shadow_valid_d   = 1'b1;
                        state_d          = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (ram_response) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ram_response) begin
                    if (!ram_mode_q) begin
                        last_read_d = ram_out;
                        if (owner_q == REQ1) r1_out_d = ram_out;
                        else                 r0_out_d = ram_out;
                    end
                    if (owner_q == REQ1) r1_ack_d = 1'b1;
                    else                 r0_ack_d = 1'b1;
                    state_d = ACK;
                end
            end
            BYPASS: begin
                // A repeated read returns the value captured by the identical earlier read.
                if (!shadow_mode_q) begin
                    if (owner_q == REQ1) r1_out_d = last_read_q;
                    else                 r0_out_d = last_read_q;
                end
                if (owner_q == REQ1) r1_ack_d = 1'b1;
                else                 r0_ack_d = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            owner_q          <= REQ0;
            ram_address_q    <= '0;
            ram_data_q       <= '0;
            ram_mode_q       <= 1'b0;
            shadow_address_q <= '0;
            shadow_data_q    <= '0;
            shadow_mode_q    <= 1'b0;
            shadow_valid_q   <= 1'b0;
            last_read_q      <= '0;
            r0_out_q         <= '0;
            r1_out_q         <= '0;
            r0_ack_q         <= 1'b0;
            r1_ack_q         <= 1'b0;
`ifdef RAM_ARB_RR_EN
            rr_ptr_q         <= REQ0;
`endif
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            ram_address_q    <= ram_address_d;
            ram_data_q       <= ram_data_d;
            ram_mode_q       <= ram_mode_d;
            shadow_address_q <= shadow_address_d;
            shadow_data_q    <= shadow_data_d;
            shadow_mode_q    <= shadow_mode_d;
            shadow_valid_q   <= shadow_valid_d;
            last_read_q      <= last_read_d;
            r0_out_q         <= r0_out_d;
            r1_out_q         <= r1_out_d;
            r0_ack_q         <= r0_ack_d;
            r1_ack_q         <= r1_ack_d;
`ifdef RAM_ARB_RR_EN
            rr_ptr_q         <= rr_ptr_d;
`endif
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_mode    = ram_mode_q;
    assign r0_ack      = r0_ack_q;
    assign r1_ack      = r1_ack_q;
    assign r0_out      = r0_out_q;
    assign r1_out      = r1_out_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter with a behavioural
// change-triggered ram model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE   = 4096;
    localparam int NVEC   = 12;

`ifdef RAM_ARB_RR_EN
    localparam logic CONTEND_FIRST = 1'b1;
`else
    localparam logic CONTEND_FIRST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              r0_req, r0_mode, r1_req, r1_mode;
    logic [ADDR_W-1:0] r0_address, r1_address;
    logic [DATA_W-1:0] r0_data, r1_data;
    logic              r0_ack, r1_ack;
    logic [DATA_W-1:0] r0_out, r1_out;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_mode;
    logic              ram_response;
    logic [DATA_W-1:0] ram_out;
    logic              busy, owner;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_r0_out = '0;
    logic [DATA_W-1:0] exp_r1_out = '0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_req       (r0_req),
        .r0_mode      (r0_mode),
        .r0_address   (r0_address),
        .r0_data      (r0_data),
        .r0_ack       (r0_ack),
        .r0_out       (r0_out),
        .r1_req       (r1_req),
        .r1_mode      (r1_mode),
        .r1_address   (r1_address),
        .r1_data      (r1_data),
        .r1_ack       (r1_ack),
        .r1_out       (r1_out),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_mode     (ram_mode),
        .ram_response (ram_response),
        .ram_out      (ram_out),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    // Ram model: starts an op when its inputs differ from the last accepted tuple,
    // holds response high for ram_lat edges, then completes.
    logic [DATA_W-1:0]        mem [0:SIZE-1];
    logic [ADDR_W+DATA_W:0]   prev_tuple = '0;
    logic [ADDR_W-1:0]        op_address = '0;
    logic [DATA_W-1:0]        op_data    = '0;
    logic                     op_mode    = 1'b0;
    logic                     ram_resp_q = 1'b0;
    logic [DATA_W-1:0]        ram_out_q  = '0;
    logic                     hold_busy  = 1'b0;
    int                       ram_cnt    = 0;
    int                       ram_lat    = 1;
    int                       ram_ops    = 0;

    assign ram_response = ram_resp_q | hold_busy;
    assign ram_out      = ram_out_q;

    always @(posedge clk) begin
        if (ram_cnt != 0) begin
            ram_cnt <= ram_cnt - 1;
            if (ram_cnt == 1) begin
                if (op_mode) mem[op_address[11:0]] <= op_data;
                else         ram_out_q <= mem[op_address[11:0]];
                ram_resp_q <= 1'b0;
            end
        end else if ({ram_address, ram_data, ram_mode} != prev_tuple) begin
            prev_tuple <= {ram_address, ram_data, ram_mode};
            op_address <= ram_address;
            op_data    <= ram_data;
            op_mode    <= ram_mode;
            ram_cnt    <= ram_lat;
            ram_resp_q <= 1'b1;
            ram_ops    <= ram_ops + 1;
        end
    end

    typedef struct {
        string             name;
        logic              r0_req;
        logic              r0_mode;
        logic [ADDR_W-1:0] r0_addr;
        logic [DATA_W-1:0] r0_data;
        logic [DATA_W-1:0] r0_exp;
        logic              r1_req;
        logic              r1_mode;
        logic [ADDR_W-1:0] r1_addr;
        logic [DATA_W-1:0] r1_data;
        logic [DATA_W-1:0] r1_exp;
        logic              first_id;
        int                first_lat;
        int                ops;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mkVec(input string name,
                                   input logic a_req, input logic a_mode, input logic [31:0] a_addr,
                                   input logic [31:0] a_data, input logic [31:0] a_exp,
                                   input logic b_req, input logic b_mode, input logic [31:0] b_addr,
                                   input logic [31:0] b_data, input logic [31:0] b_exp,
                                   input logic first, input int lat, input int ops);
        vec_t v;
        v.name = name;
        v.r0_req = a_req; v.r0_mode = a_mode; v.r0_addr = a_addr; v.r0_data = a_data; v.r0_exp = a_exp;
        v.r1_req = b_req; v.r1_mode = b_mode; v.r1_addr = b_addr; v.r1_data = b_data; v.r1_exp = b_exp;
        v.first_id = first; v.first_lat = lat; v.ops = ops;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "/ram_address"}, 64'(ram_address), 0);
        checkOutput({tag, "/ram_data"},    64'(ram_data),    0);
        checkOutput({tag, "/ram_mode"},    64'(ram_mode),    0);
        checkOutput({tag, "/acks"},        64'({r0_ack, r1_ack}), 0);
        checkOutput({tag, "/r0_out"},      64'(r0_out),      0);
        checkOutput({tag, "/r1_out"},      64'(r1_out),      0);
        checkOutput({tag, "/busy"},        64'(busy),        0);
        checkOutput({tag, "/owner"},       64'(owner),       0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        r0_mode = v.r0_mode; r0_address = v.r0_addr; r0_data = v.r0_data; r0_req = v.r0_req;
        r1_mode = v.r1_mode; r1_address = v.r1_addr; r1_data = v.r1_data; r1_req = v.r1_req;
    endtask

    // Drives one vector, drops each req on its ack, and checks winner order,
    // first-ack latency, read data, data hold and ram traffic.
    task automatic runVector(input vec_t v);
        int   ops0;
        int   cycles;
        int   lat_first;
        bit   got_first;
        logic first_id;
        bit   p0, p1;
        applyStimulus(v);
        ops0 = ram_ops;
        p0 = v.r0_req; p1 = v.r1_req;
        cycles = 0; lat_first = 0; got_first = 0; first_id = 1'b0;
        while ((p0 || p1) && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (r0_ack || r1_ack) checkOutput({v.name, "/ack_excl"}, 64'(r0_ack & r1_ack), 0);
            if (r0_ack) begin
                checkOutput({v.name, "/r0_ack_req"}, 64'(p0), 1);
                if (!got_first) begin got_first = 1; first_id = 1'b0; lat_first = cycles; end
                if (!v.r0_mode && p0) begin
                    checkOutput({v.name, "/r0_out"}, 64'(r0_out), 64'(v.r0_exp));
                    exp_r0_out = v.r0_exp;
                end
                p0 = 0; r0_req = 1'b0;
            end
            if (r1_ack) begin
                checkOutput({v.name, "/r1_ack_req"}, 64'(p1), 1);
                if (!got_first) begin got_first = 1; first_id = 1'b1; lat_first = cycles; end
                if (!v.r1_mode && p1) begin
                    checkOutput({v.name, "/r1_out"}, 64'(r1_out), 64'(v.r1_exp));
                    exp_r1_out = v.r1_exp;
                end
                p1 = 0; r1_req = 1'b0;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checkOutput({v.name, "/pending"},   64'({p0, p1}), 0);
        checkOutput({v.name, "/first_id"},  64'(first_id), 64'(v.first_id));
        checkOutput({v.name, "/first_lat"}, 64'(lat_first), 64'(v.first_lat));
        repeat (3) @(posedge clk);
        #1;
        checkOutput({v.name, "/r0_hold"},  64'(r0_out), 64'(exp_r0_out));
        checkOutput({v.name, "/r1_hold"},  64'(r1_out), 64'(exp_r1_out));
        checkOutput({v.name, "/ram_ops"},  64'(ram_ops - ops0), 64'(v.ops));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        r0_req = 1'b0; r0_mode = 1'b0; r0_address = '0; r0_data = '0;
        r1_req = 1'b0; r1_mode = 1'b0; r1_address = '0; r1_data = '0;

        //                 name          r0: req mode addr   data          exp          r1: req mode addr data  exp       first       lat ops
        vecs[0]  = mkVec("wr0_a5",      1, 1, 5,    32'hDEADBEEF, 0,            0, 0, 0, 0,     0,       1'b0,          4, 1);
        vecs[1]  = mkVec("rd0_a5",      1, 0, 5,    0,            32'hDEADBEEF, 0, 0, 0, 0,     0,       1'b0,          4, 1);
        vecs[2]  = mkVec("contend",     1, 1, 1,    32'h11,       0,            1, 1, 2, 32'h22, 0,      CONTEND_FIRST, 4, 2);
        vecs[3]  = mkVec("wr1_a7",      0, 0, 0,    0,            0,            1, 1, 7, 32'h77, 0,      1'b1,          4, 1);
        vecs[4]  = mkVec("rd1_a7",      0, 0, 0,    0,            0,            1, 0, 7, 0,     32'h77,  1'b1,          4, 1);
        vecs[5]  = mkVec("rd1_a7_rep",  0, 0, 0,    0,            0,            1, 0, 7, 0,     32'h77,  1'b1,          2, 0);
        vecs[6]  = mkVec("rd0_a7_rep",  1, 0, 7,    0,            32'h77,       0, 0, 0, 0,     0,       1'b0,          2, 0);
        vecs[7]  = mkVec("rd0_a7_mod",  1, 0, 4103, 0,            32'h77,       0, 0, 0, 0,     0,       1'b0,          2, 0);
        vecs[8]  = mkVec("wr0_a9",      1, 1, 9,    32'h99,       0,            0, 0, 0, 0,     0,       1'b0,          4, 1);
        vecs[9]  = mkVec("rd0_a9_raw",  1, 0, 9,    32'h99,       32'h99,       0, 0, 0, 0,     0,       1'b0,          4, 1);
        vecs[10] = mkVec("wr0_a9_again",1, 1, 9,    32'h99,       0,            0, 0, 0, 0,     0,       1'b0,          4, 1);
        vecs[11] = mkVec("wr1_a9_rep",  0, 0, 0,    0,            0,            1, 1, 9, 32'h99, 0,      1'b1,          2, 0);

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) runVector(vecs[i]);

        // Ram still busy while idle: no grant until ram_response falls.
        $display("[TB] ram busy at idle");
        @(negedge clk);
        hold_busy = 1'b1;
        r0_mode = 1'b0; r0_address = 1; r0_data = '0; r0_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("hold/busy", 64'(busy), 0);
        end
        hold_busy = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (r0_ack) begin
                seen = 1;
                checkOutput("hold/r0_out", 64'(r0_out), 64'h11);
                exp_r0_out = 32'h11;
                r0_req = 1'b0;
            end
        end
        r0_req = 1'b0;
        checkOutput("hold/ack_seen", 64'(seen), 1);
        repeat (3) @(posedge clk);

        // Reset while waiting for the ram to finish.
        $display("[TB] reset mid-operation");
        ram_lat = 4;
        @(negedge clk);
        r0_mode = 1'b0; r0_address = 2; r0_data = '0; r0_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = busy;
        end
        checkOutput("midop/grant", 64'(seen), 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midop/ram_busy", 64'(ram_response), 1);
        checkOutput("midop/busy",     64'(busy), 1);
        rst_n = 1'b0;
        r0_req = 1'b0;
        #1;
        checkResetState("midop_reset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("midop/no_ack", 64'({r0_ack, r1_ack}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ram_lat = 1;
        exp_r0_out = '0;
        exp_r1_out = '0;
        repeat (12) @(posedge clk);
        runVector(mkVec("rd0_a2_after_rst", 1, 0, 2, 0, 32'h22, 0, 0, 0, 0, 0, 1'b0, 4, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
